// File: rtl/serial_pkg.sv
// Shared constants for the bit-serial arithmetic blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_pkg;

  // Default operand width for serial_adder.
  localparam int DEF_WIDTH = 8;

  // Controller state encodings, kept as plain constants so other blocks
  // and benches can compare against them without the enum type.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Majority of three bits: the carry of a one-bit full add.
  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell, reusable by serial and ripple datapaths.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no handshake.
module full_adder
  import serial_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and carry of the three input bits.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = maj3(a, b, cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, one bit per clock, LSB first.
// Latency: start accepted at edge E, sum/carry_out/done update at edge E+WIDTH.
// Backpressure: start is ignored while busy; one operation per WIDTH+2 cycles.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,          // legal range 2..32
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             c_ff;
  logic [CNT_W-1:0] cnt;

  logic fa_s;
  logic fa_co;
  logic accept;
  logic shift_en;
  logic last_bit;

  // The single serial bit slice: current LSBs plus the registered carry.
  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_ff),
    .s    (fa_s),
    .cout (fa_co)
  );

  // Control decode from the state register only, so busy/done never glitch
  // on input changes.
  always_comb begin
    accept   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    last_bit = (cnt == CNT_W'(WIDTH - 1));
    case (state)
      S_IDLE:  accept   = start;
      S_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Next result word: new sum bit enters at the MSB, older bits move down.
  // The LSB falls off only after all WIDTH bits have been collected.
  always_comb begin
    res_nxt            = res_sr >> 1;
    res_nxt[WIDTH-1]   = fa_s;
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT -> DONE after the
  // last bit, DONE always returns to IDLE after one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand shift registers, carry flop and bit counter. Reset clears any
  // partial work so an aborted sum can never reach the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      c_ff   <= 1'b0;
      cnt    <= '0;
    end else if (shift_en) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
      c_ff   <= fa_co;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers: only updated on the edge that enters DONE, so they
  // hold the previous answer through the whole next operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (shift_en && last_bit) begin
      sum       <= res_nxt;
      carry_out <= fa_co;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, corner sequences,
// random operands, with a result scoreboard driven by the done pulse.
module tb_serial_adder;
  import serial_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int tests = 0;
  int fails = 0;

  logic [W:0] sb[$];
  logic       prev_done = 1'b0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[6];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done.
  always @(posedge clk) begin
    #1;
    if (dut.state == ST_IDLE) check("busy_in_idle", {31'd0, busy}, 32'd0);
    if (done && prev_done) check("done_two_cycles", 32'd1, 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = sb.pop_front();
        check("sb_result", {23'd0, carry_out, sum}, {23'd0, e});
      end
    end
    prev_done = done;
  end

  // One operation from idle: accept, measure latency, return to idle.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob);
    int k;
    start = 1'b1;
    a = oa;
    b = ob;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    sb.push_back({1'b0, oa} + {1'b0, ob});
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    k = 0;
    for (int i = 1; i <= 3 * W; i++) begin
      tick();
      if (done) begin
        k = i;
        break;
      end
    end
    check("latency", k, W);
    tick();
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("done_low_after", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int d1, d2;
    vecs[0] = '{a: 8'h35, b: 8'h4A, s: 8'h7F, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, co: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, s: 8'h00, co: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, co: 1'b1};
    vecs[5] = '{a: 8'h01, b: 8'h7F, s: 8'h80, co: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_co", {31'd0, carry_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b);
      check("vec_sum", {24'd0, sum}, {24'd0, vecs[i].s});
      check("vec_co", {31'd0, carry_out}, {31'd0, vecs[i].co});
      tick();
      check("vec_sum_hold", {24'd0, sum}, {24'd0, vecs[i].s});
    end

    // start held high; operands change while busy.
    start = 1'b1;
    a = 8'h10;
    b = 8'h20;
    tick();
    a = 8'hAA;
    b = 8'h55;
    sb.push_back(9'h030);
    sb.push_back(9'h0FF);
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == W + 2) start = 1'b0;
      if (done && d1 == 0) begin
        d1 = i;
        check("held_sum1", {24'd0, sum}, 32'h30);
        check("held_co1", {31'd0, carry_out}, 32'd0);
      end else if (done && d2 == 0) begin
        d2 = i;
        check("held_sum2", {24'd0, sum}, 32'hFF);
        check("held_co2", {31'd0, carry_out}, 32'd0);
      end
    end
    check("held_lat1", d1, W);
    check("held_lat2", d2, 2 * W + 2);
    check("held_idle", {31'd0, busy}, 32'd0);

    // Reset at the 4th SHIFT edge discards the partial sum.
    start = 1'b1;
    a = 8'hF0;
    b = 8'h0F;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_sum", {24'd0, sum}, 32'd0);
    check("mid_rst_co", {31'd0, carry_out}, 32'd0);
    rst_n = 1'b1;
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    tick();
    start = 1'b0;
    sb.push_back(9'h003);
    check("post_rst_accept", {31'd0, busy}, 32'd1);
    for (int i = 0; i < W + 2; i++) tick();
    check("post_rst_sum", {24'd0, sum}, 32'h03);

    // Random operands against the scoreboard.
    for (int i = 0; i < 200; i++) begin
      do_op(W'($urandom), W'($urandom));
    end

    tick();
    tick();
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
